// File: rtl/elite_spi_slave_mw_if.sv
// rtl/elite_spi_slave_mw_if.sv - fabric-side transmit/receive/status bundle of the SPI slave
interface elite_spi_slave_mw_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] Tx_Data;
   logic              Tx_Valid;
   logic              Tx_Ready;
   logic [WORD_W-1:0] Rx_Data;
   logic              Rx_Valid;
   logic              Tx_Underrun;
   logic              Frame_Abort;
   logic              Busy;
   logic [15:0]       Word_Cnt;

   // Fabric logic that feeds and consumes SPI words
   modport master (
      output Tx_Data, Tx_Valid,
      input  Tx_Ready, Rx_Data, Rx_Valid, Tx_Underrun, Frame_Abort, Busy, Word_Cnt
   );

   // The SPI slave itself
   modport slave (
      input  Tx_Data, Tx_Valid,
      output Tx_Ready, Rx_Data, Rx_Valid, Tx_Underrun, Frame_Abort, Busy, Word_Cnt
   );
endinterface

// File: rtl/elite_spi_slave_mw.sv
// rtl/elite_spi_slave_mw.sv - parametrised SPI slave with double-buffered transmit
module elite_spi_slave_mw #(
   parameter int              WORD_W    = 8,
   parameter bit              CPOL      = 1'b0,
   parameter bit              CPHA      = 1'b0,
   parameter bit              MSB_FIRST = 1'b1,
   parameter logic [WORD_W-1:0] FILL    = '0
) (
   input  logic MClk,
   input  logic MRst_N,
   input  logic SPI_SCLK,
   input  logic SPI_CSEL,
   input  logic SPI_MOSI,
   output logic SPI_MISO,
   output logic SPI_MISO_OE,
   elite_spi_slave_mw_if.slave bus
);
   localparam int              BW       = $clog2(WORD_W);
   localparam logic [BW-1:0]   LAST_BIT = BW'(WORD_W - 1);

   logic [2:0]        sclk_sync;
   logic [2:0]        csel_sync;
   logic [1:0]        mosi_sync;
   logic [BW-1:0]     bitcnt;
   logic [WORD_W-1:0] rx_shift;
   logic [WORD_W-1:0] rx_next;
   logic [WORD_W-1:0] tx_shift;
   logic [WORD_W-1:0] hold_data;
   logic              hold_full;
   logic [15:0]       word_cnt;

   logic cs_active;
   logic sclk_lead;
   logic sclk_trail;
   logic sample_edge;
   logic shift_edge;
   logic csel_fall;
   logic csel_rise;
   logic word_done;
   logic tx_load;
   logic tx_accept;

   // Edges are qualified by the older CSEL stage so a sample edge that lands
   // together with the CSEL rise still completes its word.
   assign cs_active   = ~csel_sync[2];
   assign sclk_lead   = cs_active && (sclk_sync[2] == CPOL) && (sclk_sync[1] != CPOL);
   assign sclk_trail  = cs_active && (sclk_sync[2] != CPOL) && (sclk_sync[1] == CPOL);
   assign sample_edge = CPHA ? sclk_trail : sclk_lead;
   assign shift_edge  = CPHA ? sclk_lead  : sclk_trail;
   assign csel_fall   =  csel_sync[2] & ~csel_sync[1];
   assign csel_rise   = ~csel_sync[2] &  csel_sync[1];
   assign word_done   = sample_edge && (bitcnt == LAST_BIT);
   assign rx_next     = MSB_FIRST ? {rx_shift[WORD_W-2:0], mosi_sync[1]}
                                  : {mosi_sync[1], rx_shift[WORD_W-1:1]};
   // With CPHA=0 the first bit must be on MISO before the first SCLK edge,
   // so the frame's first word is loaded at CSEL fall instead.
   assign tx_load     = CPHA ? (shift_edge && (bitcnt == '0))
                             : (csel_fall || (shift_edge && (bitcnt == '0)));
   assign tx_accept   = bus.Tx_Valid & ~hold_full;

   assign SPI_MISO     = MSB_FIRST ? tx_shift[WORD_W-1] : tx_shift[0];
   assign SPI_MISO_OE  = cs_active;
   assign bus.Busy     = cs_active;
   assign bus.Tx_Ready = ~hold_full;
   assign bus.Word_Cnt = word_cnt;

   // Bring the asynchronous pins into MClk, resetting to the idle bus state
   always_ff @(posedge MClk or negedge MRst_N) begin
      if (!MRst_N) begin
         sclk_sync <= {3{CPOL}};
         csel_sync <= 3'b111;
         mosi_sync <= 2'b00;
      end else begin
         sclk_sync <= {sclk_sync[1:0], SPI_SCLK};
         csel_sync <= {csel_sync[1:0], SPI_CSEL};
         mosi_sync <= {mosi_sync[0], SPI_MOSI};
      end
   end

   // Receive shifter, word completion, frame word counter and abort detection
   always_ff @(posedge MClk or negedge MRst_N) begin
      if (!MRst_N) begin
         rx_shift        <= '0;
         bitcnt          <= '0;
         word_cnt        <= '0;
         bus.Rx_Data     <= '0;
         bus.Rx_Valid    <= 1'b0;
         bus.Frame_Abort <= 1'b0;
      end else begin
         bus.Rx_Valid    <= 1'b0;
         bus.Frame_Abort <= 1'b0;
         if (sample_edge) begin
            rx_shift <= rx_next;
            if (word_done) begin
               bitcnt       <= '0;
               bus.Rx_Data  <= rx_next;
               bus.Rx_Valid <= 1'b1;
               if (word_cnt != 16'hFFFF)
                  word_cnt <= word_cnt + 16'd1;
            end else begin
               bitcnt <= bitcnt + BW'(1);
            end
         end
         if (csel_rise) begin
            bitcnt          <= '0;
            word_cnt        <= '0;
            rx_shift        <= '0;
            bus.Frame_Abort <= (bitcnt != '0) && !word_done;
         end
      end
   end

   // Holding register handshake and transmit shifter; a load from an empty
   // holding register sends FILL even if a word is accepted that same cycle
   always_ff @(posedge MClk or negedge MRst_N) begin
      if (!MRst_N) begin
         hold_full       <= 1'b0;
         hold_data       <= '0;
         tx_shift        <= '0;
         bus.Tx_Underrun <= 1'b0;
      end else begin
         bus.Tx_Underrun <= 1'b0;
         if (tx_accept) begin
            hold_full <= 1'b1;
            hold_data <= bus.Tx_Data;
         end
         if (tx_load) begin
            if (hold_full) begin
               tx_shift  <= hold_data;
               hold_full <= 1'b0;
            end else begin
               tx_shift        <= FILL;
               bus.Tx_Underrun <= 1'b1;
            end
         end else if (shift_edge) begin
            tx_shift <= MSB_FIRST ? {tx_shift[WORD_W-2:0], 1'b0} : {1'b0, tx_shift[WORD_W-1:1]};
         end
      end
   end
endmodule

// File: doc/elite_spi_slave_mw.md
# elite_spi_slave_mw

Parametrised SPI slave for the FPGA fabric: configurable word width, SPI mode (CPOL/CPHA) and bit order. It has a double-buffered transmit path with a valid/ready handshake, a receive-word strobe, underrun/abort flags and a MISO output-enable. It sits between an external SPI master (pins) and fabric logic in the MClk domain, replacing the fixed 8-bit, mode-0-only slave.

## Interface
- WORD_W, 8: bits per SPI word, 4..32
- CPOL, 0: SCLK idle level
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge
- MSB_FIRST, 1: 1 = MSB first on both MOSI and MISO; 0 = LSB first
- FILL, 0: WORD_W-bit word transmitted on underrun

Ports:
- MClk  in  1  system clock, 50 MHz
- MRst_N  in  1  asynchronous, active-low reset
- SPI_SCLK  in  1  SPI clock from master (asynchronous)
- SPI_CSEL  in  1  chip select, active low (asynchronous)
- SPI_MOSI  in  1  master-out data (asynchronous)
- SPI_MISO  out  1  slave-out data
- SPI_MISO_OE  out  1  MISO drive enable, for an external tri-state buffer
- Tx_Data  in  WORD_W  next word to transmit
- Tx_Valid  in  1  Tx_Data valid
- Tx_Ready  out  1  holding register empty
- Rx_Data  out  WORD_W  last complete received word
- Rx_Valid  out  1  one-cycle strobe: Rx_Data updated
- Tx_Underrun  out  1  one-cycle strobe: FILL loaded
- Frame_Abort  out  1  one-cycle strobe: CSEL deasserted mid-word
- Busy  out  1  synchronized CSEL active
- Word_Cnt  out  16  complete words received in the current frame

## Operation
- Synchronizers:
  - SCLK and CSEL use 3-FF shift registers; MOSI uses 2 FFs. All reset to idle (SCLK = CPOL, CSEL = 1, MOSI = 0).
  - Edges are detected on the top two stages.
- Edge definitions:
  - Leading edge = synchronized SCLK transition away from CPOL; trailing edge = transition back to CPOL.
  - sample_edge = leading if CPHA=0, else trailing; shift_edge = the other one.
  - Edges are ignored while CSEL is inactive.
- Receive:
  - On each sample_edge, the MOSI sync output shifts into rx_shift (left if MSB_FIRST, else right) and bitcnt ($clog2(WORD_W) bits) increments.
  - When bitcnt = WORD_W-1 at a sample_edge: the next cycle Rx_Data takes the full word, Rx_Valid pulses, bitcnt wraps to 0, and Word_Cnt increments (saturates at 16'hFFFF).
  - Rx_Data holds until the next complete word.
- Transmit holding register:
  - Tx_Ready = holding empty.
  - A Tx_Valid & Tx_Ready cycle loads holding.
  - Tx_Valid while Tx_Ready = 0 is ignored.
- Word load (tx_shift from holding, or FILL when holding is empty):
  - CPHA=0: at CSEL falling edge, and on the shift_edge following the last sample_edge of a word.
  - CPHA=1: on the first shift_edge of each word (bitcnt = 0).
  - Other shift_edges shift tx_shift by one bit.
  - Loading from holding sets Tx_Ready the next cycle.
  - Loading FILL pulses Tx_Underrun for one cycle.
- SPI_MISO = tx_shift[WORD_W-1] if MSB_FIRST, else tx_shift[0].
- SPI_MISO_OE = Busy.
- CSEL rising edge:
  - bitcnt and Word_Cnt clear.
  - rx_shift is discarded.
  - Frame_Abort pulses if bitcnt ≠ 0.
  - The holding register is kept.
- Simultaneous events:
  - Tx_Valid accepted in the same cycle as a word load from an empty holding register: FILL is sent and Tx_Underrun pulses; the new word stays in holding for the next word.
  - CSEL rise coinciding with a completing sample_edge: the word completes (Rx_Valid) and Frame_Abort does not pulse.
- Reset (asynchronous, any time, including mid-frame):
  - Outputs: SPI_MISO=0, SPI_MISO_OE=0, Tx_Ready=1, Rx_Data=0, Rx_Valid=0, Tx_Underrun=0, Frame_Abort=0, Busy=0, Word_Cnt=0.
  - Internal: shift registers 0, holding empty, bitcnt 0.

## Timing
- SCLK frequency must not exceed MClk/8 (each SCLK level ≥ 4 MClk cycles). CSEL setup/hold to the first/last SCLK edge must be ≥ 4 MClk cycles.
- Pin edge to internal edge detect: 3 MClk cycles. Rx_Valid follows 1 cycle after the detected final sample_edge, i.e. 4 cycles after the pin.
- MISO changes 3-4 MClk cycles after the SCLK shift pin edge, within half an SCLK period.
- Tx_Ready deasserts the cycle after acceptance and reasserts the cycle after a load from holding.
- Back-to-back words: at least one full SCLK period is available to refill holding. If it is not refilled, the result is an underrun, not corruption.

## Test plan
- Mode 0, WORD_W=8: master sends 8'hA5 with Tx holding 8'h3C → MISO bits 0,0,1,1,1,1,0,0; Rx_Data=8'hA5; Rx_Valid one cycle; Word_Cnt=1; Tx_Ready rises after the CSEL-fall load.
- Modes 1/2/3 and MSB_FIRST=0, WORD_W=16: send 16'h1234 / transmit 16'hBEEF → exact bit order on both lines; Rx_Data=16'h1234.
- Three back-to-back words, holding refilled only for the first → words 2 and 3 send FILL=0; Tx_Underrun pulses twice.
- CSEL raised after 5 bits → Frame_Abort one pulse, no Rx_Valid, Word_Cnt=0; the next frame receives correctly from bit 0.
- MRst_N asserted mid-word at bit 3 → all outputs at reset values immediately. After release, a full word 8'h5A is received correctly.
- Tx_Valid held high with changing data while Tx_Ready=0 → only the first accepted word is transmitted.
